// File: rtl/mem_stage.sv
// MEM stage of the pipelined MIPS core: EX/MEM and MEM/WB registers, data-memory
// handshake with timeout, alignment checking and EX-stage forwarding taps.
module mem_stage #(
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic        ex_memwrite,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_writedata,
  input  logic [4:0]  ex_writereg,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        fwd_mem_valid,
  output logic [4:0]  fwd_mem_reg,
  output logic [31:0] fwd_mem_data,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_writereg,
  output logic [31:0] wb_result,
  output logic        bus_err,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, ERROR} state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic        exm_valid_q, exm_valid_d;
  logic        exm_regwrite_q, exm_regwrite_d;
  logic        exm_memtoreg_q, exm_memtoreg_d;
  logic        exm_memwrite_q, exm_memwrite_d;
  logic [31:0] exm_aluout_q, exm_aluout_d;
  logic [31:0] exm_wdata_q, exm_wdata_d;
  logic [4:0]  exm_writereg_q, exm_writereg_d;

  logic        wb_valid_q, wb_valid_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_writereg_q, wb_writereg_d;
  logic [31:0] wb_result_q, wb_result_d;

  logic        bus_err_q, bus_err_d;
  logic        align_err_q, align_err_d;

  logic        stall;
  logic        ex_memop;

  // Register-file write enable; stores and $zero never write.
  function automatic logic wr_en(input logic vld, input logic rw, input logic mw,
                                 input logic [4:0] rd);
    return vld & rw & ~mw & (rd != 5'd0);
  endfunction

  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      IDLE:    stall = 1'b0;
      ACCESS:  stall = ~dmem_ack;
      ERROR:   stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign ex_memop = ex_valid & (ex_memtoreg | ex_memwrite);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    exm_valid_d    = exm_valid_q;
    exm_regwrite_d = exm_regwrite_q;
    exm_memtoreg_d = exm_memtoreg_q;
    exm_memwrite_d = exm_memwrite_q;
    exm_aluout_d   = exm_aluout_q;
    exm_wdata_d    = exm_wdata_q;
    exm_writereg_d = exm_writereg_q;
    wb_valid_d     = wb_valid_q;
    wb_regwrite_d  = wb_regwrite_q;
    wb_writereg_d  = wb_writereg_q;
    wb_result_d    = wb_result_q;
    bus_err_d      = bus_err_q;
    align_err_d    = align_err_q;

    if (state_q == ACCESS && !dmem_ack) begin
      cnt_d = cnt_q + TO_W'(1);
      if (cnt_d == TO_LIM) begin
        state_d   = ERROR;
        bus_err_d = 1'b1;
      end
    end

    // EX/MEM capture; an ack completes the outstanding access in the same edge
    if (!stall) begin
      exm_valid_d    = ex_valid;
      exm_regwrite_d = ex_regwrite;
      exm_memtoreg_d = ex_memtoreg;
      exm_memwrite_d = ex_memwrite;
      exm_aluout_d   = ex_aluout;
      exm_wdata_d    = ex_writedata;
      exm_writereg_d = ex_writereg;
      if (ex_memop && ex_aluout[1:0] == 2'b00) begin
        state_d = ACCESS;
        cnt_d   = '0;
      end else if (ex_memop) begin
        state_d     = ERROR;
        align_err_d = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    // MEM/WB: bubble while stalled, otherwise retire the EX/MEM instruction
    if (stall) begin
      wb_valid_d    = 1'b0;
      wb_regwrite_d = 1'b0;
    end else begin
      wb_valid_d    = exm_valid_q;
      wb_regwrite_d = wr_en(exm_valid_q, exm_regwrite_q, exm_memwrite_q, exm_writereg_q);
      wb_writereg_d = exm_writereg_q;
      wb_result_d   = exm_memtoreg_q ? dmem_rdata : exm_aluout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      exm_valid_q    <= 1'b0;
      exm_regwrite_q <= 1'b0;
      exm_memtoreg_q <= 1'b0;
      exm_memwrite_q <= 1'b0;
      exm_aluout_q   <= '0;
      exm_wdata_q    <= '0;
      exm_writereg_q <= '0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_writereg_q  <= '0;
      wb_result_q    <= '0;
      bus_err_q      <= 1'b0;
      align_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      exm_valid_q    <= exm_valid_d;
      exm_regwrite_q <= exm_regwrite_d;
      exm_memtoreg_q <= exm_memtoreg_d;
      exm_memwrite_q <= exm_memwrite_d;
      exm_aluout_q   <= exm_aluout_d;
      exm_wdata_q    <= exm_wdata_d;
      exm_writereg_q <= exm_writereg_d;
      wb_valid_q     <= wb_valid_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_writereg_q  <= wb_writereg_d;
      wb_result_q    <= wb_result_d;
      bus_err_q      <= bus_err_d;
      align_err_q    <= align_err_d;
    end
  end

  assign mem_stall     = stall;
  assign dmem_req      = (state_q == ACCESS);
  assign dmem_we       = dmem_req & exm_memwrite_q;
  assign dmem_addr     = {exm_aluout_q[31:2], 2'b00};
  assign dmem_wdata    = exm_wdata_q;
  // Loads are excluded: their data is not available until WB.
  assign fwd_mem_valid = exm_valid_q & exm_regwrite_q & ~exm_memtoreg_q & (exm_writereg_q != 5'd0);
  assign fwd_mem_reg   = exm_writereg_q;
  assign fwd_mem_data  = exm_aluout_q;
  assign wb_valid      = wb_valid_q;
  assign wb_regwrite   = wb_regwrite_q;
  assign wb_writereg   = wb_writereg_q;
  assign wb_result     = wb_result_q;
  assign bus_err       = bus_err_q;
  assign align_err     = align_err_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage of the pipelined MIPS core.
- Holds the EX/MEM pipeline register and drives the data-memory request/acknowledge handshake, stalling upstream while an access is outstanding.
- Produces the MEM/WB pipeline register consumed by register-file writeback.
- Exports forwarding taps for the EX-stage operand muxes.

Parameters:
TIMEOUT, 200, maximum cycles in ACCESS without dmem_ack before bus error
TO_W, 8, width of timeout counter (TIMEOUT < 2**TO_W)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
ex_valid  in  1  EX instruction is real (0 = bubble)
ex_regwrite  in  1  instruction writes register file
ex_memtoreg  in  1  result comes from memory (load)
ex_memwrite  in  1  store
ex_aluout  in  32  ALU result / memory address
ex_writedata  in  32  store data (rt value)
ex_writereg  in  5  destination register
mem_stall  out  1  hold EX and earlier stages this cycle
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  32  word address, bits [1:0] always 0
dmem_wdata  out  32  store data
dmem_ack  in  1  access complete this cycle; dmem_rdata valid when load
dmem_rdata  in  32  load data
fwd_mem_valid  out  1  EX/MEM holds a forwardable ALU result
fwd_mem_reg  out  5  EX/MEM destination
fwd_mem_data  out  32  EX/MEM aluout
wb_valid  out  1  MEM/WB holds a real instruction
wb_regwrite  out  1  write register file
wb_writereg  out  5  destination register
wb_result  out  32  writeback data
bus_err  out  1  sticky, timeout
align_err  out  1  sticky, misaligned access

Behaviour:
- Reset: state IDLE; all EX/MEM and MEM/WB valid/control bits 0, data 0; timeout counter 0; every output 0.
- Reset wins over all other events, including mid-ACCESS. dmem_req drops the cycle after reset is sampled. No partial result reaches WB.
- States: IDLE, ACCESS, ERROR.
- EX/MEM capture: at each edge with mem_stall=0, load ex_* into EX/MEM. An edge with mem_stall=1 holds EX/MEM.
- State on capture:
  - Non-memory instruction or bubble -> IDLE.
  - Memory op (ex_valid and (ex_memtoreg or ex_memwrite)) with ex_aluout[1:0]==0 -> ACCESS, counter cleared.
  - Misaligned memory op -> ERROR, align_err set, no request issued.
- ACCESS:
  - dmem_req=1; dmem_we/dmem_addr/dmem_wdata driven from EX/MEM and held stable until ack.
  - mem_stall = ~dmem_ack.
  - On dmem_ack: stage completes and the next state follows the newly captured instruction. Back-to-back memory ops therefore get no idle cycle.
  - Counter increments each ACCESS cycle without ack. When it reaches TIMEOUT: go to ERROR, set bus_err.
- ERROR: dmem_req=0, mem_stall=1 permanently, wb_valid=0. Only reset exits.
- IDLE: dmem_req=0, mem_stall=0.
- Latency: non-memory instruction 1 cycle EX/MEM -> MEM/WB. Memory op N cycles, where N is the number of ACCESS cycles up to and including the ack cycle.
- MEM/WB update, every edge:
  - If mem_stall=1: insert a bubble (wb_valid=0, wb_regwrite=0); other wb fields don't care.
  - Else: copy EX/MEM. wb_result = memtoreg ? dmem_rdata : aluout.
  - wb_regwrite = valid & regwrite & (writereg!=0). Stores never write.
- Forwarding: fwd_mem_valid = EX/MEM valid & regwrite & ~memtoreg & (writereg!=0). Loads are not forwardable from this stage; the hazard unit inserts the load-use stall.
- dmem_ack outside ACCESS is ignored.

Test Plan:
- ALU op: ex_aluout=0x00000010, reg 8, regwrite=1 -> next cycle fwd_mem_valid=1, fwd_mem_reg=8; following cycle wb_valid=1, wb_result=0x10, wb_writereg=8; dmem_req never 1.
- Load to 0x10000004, dmem_ack on 3rd ACCESS cycle with rdata 0xDEADBEEF:
  - dmem_req high 3 cycles; mem_stall high 2 cycles; wb_valid=0 during the stall.
  - Then wb_result=0xDEADBEEF, wb_regwrite=1.
- Store 0xCAFEF00D to 0x00000020 with immediate ack, followed by a load to 0x00000020 with immediate ack:
  - Two consecutive req cycles, we=1 then 0.
  - mem_stall never 1.
  - Store produces wb_regwrite=0.
- TIMEOUT=4, load with no ack -> dmem_req high 4 cycles then 0; bus_err=1; mem_stall stays 1; wb_valid stays 0 until reset.
- Load with addr 0x00000102 -> dmem_req stays 0, align_err=1, mem_stall=1.
- Reset asserted in 2nd ACCESS cycle:
  - Next cycle dmem_req=0, mem_stall=0, wb_valid=0, errors 0.
  - A subsequent ALU op completes normally.
